usb_token_tx: RTL and testbench

//  Host-side USB token packet builder sitting directly downstream of usb_sof_generator.

---
 rtl/usb_token_pkg.sv | 53 +++++
 rtl/usb_token_tx_crc.sv | 11 +
 rtl/usb_token_tx.sv | 119 +++++++++++
 tb/tb_usb_token_tx.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_token_pkg.sv
// Shared definitions for the USB token builder: token types, PIDs, FSM states, CRC5 helper.
package usb_token_pkg;

    typedef enum logic [1:0] {
        TOK_OUT   = 2'b00,
        TOK_IN    = 2'b01,
        TOK_SOF   = 2'b10,
        TOK_SETUP = 2'b11
    } token_type_e;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_B1,
        ST_B2,
        ST_DONE,
        ST_GAP
    } state_e;

    function automatic logic [3:0] pid_of(input logic [1:0] t);
        logic [3:0] p;
        case (t)
            TOK_OUT:   p = PID_OUT;
            TOK_IN:    p = PID_IN;
            TOK_SOF:   p = PID_SOF;
            default:   p = PID_SETUP;
        endcase
        return p;
    endfunction

    // Returns the CRC already inverted and bit-reversed, ready to drop into B2[7:3].
    function automatic logic [4:0] crc5_11(input logic [10:0] field);
        logic [4:0] c;
        logic [4:0] r;
        logic       fb;
        c = 5'b11111;
        r = 5'b00000;
        for (int i = 0; i < 11; i++) begin
            fb = field[i] ^ c[4];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        for (int i = 0; i < 5; i++) begin
            r[i] = ~c[4-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_token_tx_crc.sv
// Combinational CRC5 over an 11-bit token field; output is in B2[7:3] bit order.
module usb_crc5_11
    import usb_token_pkg::*;
(
    input  logic [10:0] field,
    output logic [4:0]  crc
);

    assign crc = crc5_11(field);

endmodule

// File: rtl/usb_token_tx.sv
// USB host token packet builder: PID + 11-bit field + CRC5 streamed over UTMI TX.
// Optional USB_TOKEN_IPG_EN inserts an IPG_CYCLES idle gap after each packet.
module usb_token_tx
    import usb_token_pkg::*;
#(
    parameter int unsigned IPG_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        token_start,
    input  logic [1:0]  token_type,
    input  logic [6:0]  token_addr,
    input  logic [3:0]  token_endp,
    input  logic [10:0] token_frame,
    output logic        token_ready,
    output logic        token_done,
    output logic [7:0]  utmi_tx_data,
    output logic        utmi_tx_valid,
    input  logic        utmi_tx_ready
);

    state_e      state_q, state_d;
    logic [3:0]  pid_q, pid_d;
    logic [10:0] field_q, field_d;
    logic [4:0]  crc_q, crc_d;
    logic [4:0]  crc_w;

    usb_crc5_11 u_crc (
        .field (field_q),
        .crc   (crc_w)
    );

`ifdef USB_TOKEN_IPG_EN
    localparam int GW = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES) : 1;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`else
    logic ipg_unused;
    assign ipg_unused = ^IPG_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        pid_d         = pid_q;
        field_d       = field_q;
        crc_d         = crc_q;
        token_ready   = 1'b0;
        token_done    = 1'b0;
        utmi_tx_valid = 1'b0;
        utmi_tx_data  = 8'h00;
`ifdef USB_TOKEN_IPG_EN
        gap_cnt_d     = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                token_ready = 1'b1;
                if (token_start) begin
                    pid_d   = pid_of(token_type);
                    field_d = (token_type == TOK_SOF) ? token_frame : {token_endp, token_addr};
                    state_d = ST_PID;
                end
            end
            ST_PID: begin
                utmi_tx_valid = 1'b1;
                utmi_tx_data  = {~pid_q, pid_q};
                // Field is stable from here on, so the CRC register settles long before B2.
                crc_d         = crc_w;
                if (utmi_tx_ready) state_d = ST_B1;
            end
            ST_B1: begin
                utmi_tx_valid = 1'b1;
                utmi_tx_data  = field_q[7:0];
                if (utmi_tx_ready) state_d = ST_B2;
            end
            ST_B2: begin
                utmi_tx_valid = 1'b1;
                utmi_tx_data  = {crc_q, field_q[10:8]};
                if (utmi_tx_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                token_done = 1'b1;
`ifdef USB_TOKEN_IPG_EN
                gap_cnt_d  = GW'(IPG_CYCLES - 1);
                state_d    = ST_GAP;
`else
                state_d    = ST_IDLE;
`endif
            end
`ifdef USB_TOKEN_IPG_EN
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d = ST_IDLE;
                else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pid_q   <= 4'h0;
            field_q <= 11'h000;
            crc_q   <= 5'h00;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
            field_q <= field_d;
            crc_q   <= crc_d;
        end
    end

`ifdef USB_TOKEN_IPG_EN
    always_ff @(posedge clk) begin
        if (rst) gap_cnt_q <= '0;
        else     gap_cnt_q <= gap_cnt_d;
    end
`endif

endmodule

// File: tb/tb_usb_token_tx.sv
// Directed bench for usb_token_tx with a per-cycle byte-level reference model.
module tb_usb_token_tx;

    localparam int IPG = 8;
`ifdef USB_TOKEN_IPG_EN
    localparam int GAP_EXP = IPG;
`else
    localparam int GAP_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        token_start;
    logic [1:0]  token_type;
    logic [6:0]  token_addr;
    logic [3:0]  token_endp;
    logic [10:0] token_frame;
    logic        token_ready;
    logic        token_done;
    logic [7:0]  utmi_tx_data;
    logic        utmi_tx_valid;
    logic        utmi_tx_ready;

    always #5 clk = ~clk;

    usb_token_tx #(.IPG_CYCLES(IPG)) dut (
        .clk           (clk),
        .rst           (rst),
        .token_start   (token_start),
        .token_type    (token_type),
        .token_addr    (token_addr),
        .token_endp    (token_endp),
        .token_frame   (token_frame),
        .token_ready   (token_ready),
        .token_done    (token_done),
        .utmi_tx_data  (utmi_tx_data),
        .utmi_tx_valid (utmi_tx_valid),
        .utmi_tx_ready (utmi_tx_ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    logic [7:0] cap[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference CRC: spec's serial rule on plain integers, then inverted/reversed into B2.
    function automatic logic [7:0] m_b2(input logic [10:0] f);
        int c = 31;
        int fb;
        logic [7:0] b;
        for (int i = 0; i < 11; i++) begin
            fb = int'(f[i]) ^ ((c >> 4) & 1);
            c  = ((c << 1) & 31) ^ (fb != 0 ? 5 : 0);
        end
        b = {5'b00000, f[10:8]};
        for (int i = 0; i < 5; i++)
            if (((c >> (4 - i)) & 1) == 0) b[3+i] = 1'b1;
        return b;
    endfunction

    function automatic logic [7:0] m_pidbyte(input logic [1:0] t);
        case (t)
            2'b00:   return 8'hE1;
            2'b01:   return 8'h69;
            2'b10:   return 8'hA5;
            default: return 8'h2D;
        endcase
    endfunction

    function automatic logic [7:0] m_byte(input int idx, input logic [1:0] t, input logic [10:0] f);
        if (idx == 0) return m_pidbyte(t);
        if (idx == 1) return f[7:0];
        return m_b2(f);
    endfunction

    // Model phases: 0 idle, 1 sending bytes, 2 done pulse, 3 inter-packet gap.
    int         m_ph = 0;
    int         m_idx = 0;
    int         m_left = 0;
    logic       m_ok = 1'b0;
    logic [1:0] m_t = 2'b00;
    logic [10:0] m_f = 11'h000;

    always @(posedge clk) begin
        if (rst) begin
            m_ph <= 0;
            m_ok <= 1'b1;
        end else begin
            case (m_ph)
                0: if (token_start) begin
                    m_t   <= token_type;
                    m_f   <= (token_type == 2'b10) ? token_frame : {token_endp, token_addr};
                    m_idx <= 0;
                    m_ph  <= 1;
                end
                1: if (utmi_tx_ready) begin
                    if (m_idx == 2) m_ph <= 2;
                    else            m_idx <= m_idx + 1;
                end
                2: begin
                    m_ph   <= (GAP_EXP > 0) ? 3 : 0;
                    m_left <= GAP_EXP;
                end
                default: begin
                    if (m_left == 1) m_ph <= 0;
                    m_left <= m_left - 1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_ready", token_ready, m_ph == 0);
            chk("cyc_valid", utmi_tx_valid, m_ph == 1);
            chk("cyc_done", token_done, m_ph == 2);
            chk("cyc_data", utmi_tx_data, (m_ph == 1) ? m_byte(m_idx, m_t, m_f) : 8'h00);
        end
        if (utmi_tx_valid && utmi_tx_ready) cap.push_back(utmi_tx_data);
        if (token_done) done_cnt++;
    end

    always @(posedge clk) begin
        #2;
        if (ready_mode == 1) utmi_tx_ready = (cyc % 3 == 0);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Waits for token_done (bounded), returns start->done latency and post-done ready-low cycles.
    task automatic wait_done(input int t0, output int lat, output int gap);
        bit seen = 0;
        lat = -1;
        gap = -1;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (token_done) seen = 1;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            lat = cyc - t0;
            gap = 0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (token_ready) break;
                gap++;
            end
        end
        tick;
    endtask

    task automatic send(input logic [1:0] t, input logic [6:0] a, input logic [3:0] e,
                        input logic [10:0] f, output int lat, output int gap);
        int t0;
        cap.delete();
        done_cnt = 0;
        token_type  = t;
        token_addr  = a;
        token_endp  = e;
        token_frame = f;
        token_start = 1'b1;
        t0 = cyc;
        tick;
        token_start = 1'b0;
        token_type  = ~t;
        token_addr  = ~a;
        token_endp  = ~e;
        token_frame = ~f;
        wait_done(t0, lat, gap);
    endtask

    initial begin
        int lat, gap, t0;
        rst = 1'b1;
        token_start = 1'b0;
        token_type = 2'b00;
        token_addr = 7'h00;
        token_endp = 4'h0;
        token_frame = 11'h000;
        utmi_tx_ready = 1'b1;
        tick;
        tick;
        @(negedge clk);
        chk("rst_ready", token_ready, 1);
        chk("rst_valid", utmi_tx_valid, 0);
        chk("rst_done", token_done, 0);
        chk("rst_data", utmi_tx_data, 8'h00);
        tick;
        rst = 1'b0;
        tick;

        send(2'b11, 7'h00, 4'h0, 11'h000, lat, gap);
        chk("setup_n", cap.size(), 3);
        chk("setup_b0", cap[0], 8'h2D);
        chk("setup_b1", cap[1], 8'h00);
        chk("setup_b2", cap[2], 8'h10);
        chk("setup_lat", lat, 4);
        chk("setup_gap", gap, GAP_EXP);
        chk("setup_done", done_cnt, 1);

        send(2'b01, 7'h00, 4'h0, 11'h000, lat, gap);
        chk("in_b0", cap[0], 8'h69);
        chk("in_b1", cap[1], 8'h00);
        chk("in_b2", cap[2], 8'h10);
        chk("in_lat", lat, 4);

        send(2'b00, 7'h15, 4'hE, 11'h000, lat, gap);
        chk("out_b0", cap[0], 8'hE1);
        chk("out_b1", cap[1], 8'h15);
        chk("out_b2", cap[2], m_b2({4'hE, 7'h15}));
        chk("out_b2_lo", cap[2][2:0], 3'b111);

        send(2'b10, 7'h00, 4'h0, 11'h7FF, lat, gap);
        chk("sof7ff_b0", cap[0], 8'hA5);
        chk("sof7ff_b1", cap[1], 8'hFF);
        chk("sof7ff_b2", cap[2], m_b2(11'h7FF));
        chk("sof7ff_lo", cap[2][2:0], 3'b111);
        send(2'b10, 7'h7F, 4'hF, 11'h000, lat, gap);
        chk("sof0_b0", cap[0], 8'hA5);
        chk("sof0_b1", cap[1], 8'h00);
        chk("sof0_b2", cap[2], 8'h10);

        // Slow PHY: one ready in three cycles.
        ready_mode = 1;
        send(2'b00, 7'h2A, 4'h5, 11'h000, lat, gap);
        ready_mode = 0;
        utmi_tx_ready = 1'b1;
        chk("slow_n", cap.size(), 3);
        chk("slow_b1", cap[1], 8'hAA);
        chk("slow_done", done_cnt, 1);
        tick;

        // Start held for 10 cycles with the PHY stalled: one packet only.
        cap.delete();
        done_cnt = 0;
        utmi_tx_ready = 1'b0;
        token_type = 2'b11;
        token_addr = 7'h03;
        token_endp = 4'h1;
        token_start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (i == 2) begin
                token_addr = 7'h55;
                token_type = 2'b01;
            end
        end
        token_start = 1'b0;
        utmi_tx_ready = 1'b1;
        wait_done(t0, lat, gap);
        repeat (15) tick;
        chk("hold_n", cap.size(), 3);
        chk("hold_b0", cap[0], 8'h2D);
        chk("hold_b1", cap[1], 8'h83);
        chk("hold_done", done_cnt, 1);

        // Second start while B1 is on the bus.
        cap.delete();
        done_cnt = 0;
        token_type = 2'b00;
        token_addr = 7'h05;
        token_endp = 4'h2;
        token_start = 1'b1;
        t0 = cyc;
        tick;
        token_start = 1'b0;
        tick;
        token_type = 2'b01;
        token_addr = 7'h7F;
        token_start = 1'b1;
        tick;
        token_start = 1'b0;
        wait_done(t0, lat, gap);
        repeat (15) tick;
        chk("b1start_n", cap.size(), 3);
        chk("b1start_b0", cap[0], 8'hE1);
        chk("b1start_b1", cap[1], 8'h05);
        chk("b1start_b2", cap[2], m_b2({4'h2, 7'h05}));
        chk("b1start_done", done_cnt, 1);

        // Reset while B1 is on the bus: abort, no done.
        done_cnt = 0;
        token_type = 2'b10;
        token_frame = 11'h123;
        token_start = 1'b1;
        tick;
        token_start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", utmi_tx_valid, 0);
        chk("abort_ready", token_ready, 1);
        repeat (10) tick;
        chk("abort_done", done_cnt, 0);

        // Start coincident with reset is dropped.
        rst = 1'b1;
        token_start = 1'b1;
        tick;
        rst = 1'b0;
        token_start = 1'b0;
        @(negedge clk);
        chk("rststart_valid", utmi_tx_valid, 0);
        chk("rststart_ready", token_ready, 1);
        repeat (8) tick;
        chk("rststart_done", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
